// File: rtl/signal_window_pkg.sv
// Shared types and helpers for the sliding-window sum block.
package signal_window_pkg;

    localparam int unsigned MAX_LOG2_DEPTH = 8;

    typedef enum logic [0:0] {
        StFill,
        StRun
    } state_e;

    // The sum of 2**log2_depth samples of width bits needs log2_depth extra bits.
    function automatic int unsigned out_width(int unsigned width, int unsigned log2_depth);
        return width + log2_depth;
    endfunction

endpackage

// File: rtl/signal_window_buf.sv
// N x WIDTH circular sample store; rd_data_o is the oldest entry, at the write pointer.
module signal_window_buf #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned LOG2_DEPTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_o
);

    localparam int unsigned DEPTH = 2 ** LOG2_DEPTH;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [LOG2_DEPTH-1:0] ptr_q;
    logic [LOG2_DEPTH-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (wr_en_i) begin
            ptr_d = (ptr_q == LOG2_DEPTH'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Contents are left unreset; the fill count in the parent masks stale entries.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[ptr_q];

endmodule

// File: rtl/signal_window_sum.sv
// Sliding-window sum of the last 2**LOG2_DEPTH valid samples, one result per valid beat.
// Define SIGNAL_WINDOW_AVG_EN to output the truncating average instead of the raw sum.
module signal_window_sum
    import signal_window_pkg::*;
#(
    parameter  int unsigned WIDTH      = 32,
    parameter  int unsigned LOG2_DEPTH = 3,
    localparam int unsigned OUT_WIDTH  = out_width(WIDTH, LOG2_DEPTH)
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [WIDTH-1:0]     IN_VALUE,
    input  logic                 IN_VALID,
    output logic [OUT_WIDTH-1:0] OUT_VALUE,
    output logic                 OUT_VALID
);

    localparam int unsigned DEPTH = 2 ** LOG2_DEPTH;
    localparam int unsigned CNT_W = LOG2_DEPTH + 1;

    if (LOG2_DEPTH < 1 || LOG2_DEPTH > MAX_LOG2_DEPTH) begin : g_bad_depth
        $error("signal_window_sum: LOG2_DEPTH out of range");
    end

    state_e               state_q;
    logic [CNT_W-1:0]     count_q;
    logic [OUT_WIDTH-1:0] sum_q;
    logic [OUT_WIDTH-1:0] sum_d;
    logic [OUT_WIDTH-1:0] out_value_q;
    logic [OUT_WIDTH-1:0] out_value_d;
    logic                 out_valid_q;
    logic [WIDTH-1:0]     oldest;
    logic                 buf_wr_en;

    assign buf_wr_en = IN_VALID & ~RESET;

    signal_window_buf #(
        .WIDTH      (WIDTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_buf (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .wr_en_i   (buf_wr_en),
        .wr_data_i (IN_VALUE),
        .rd_data_o (oldest)
    );

    // Oldest is only subtracted once the window is full, so it is always part of sum_q.
    always_comb begin
        sum_d = sum_q + OUT_WIDTH'(IN_VALUE);
        if (state_q == StRun) begin
            sum_d = sum_d - OUT_WIDTH'(oldest);
        end
    end

`ifdef SIGNAL_WINDOW_AVG_EN
    always_comb begin
        out_value_d = sum_d >> LOG2_DEPTH;
    end
`else
    always_comb begin
        out_value_d = sum_d;
    end
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StFill;
            count_q     <= '0;
            sum_q       <= '0;
            out_value_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (IN_VALID) begin
                sum_q <= sum_d;
                unique case (state_q)
                    StFill: begin
                        count_q <= count_q + 1'b1;
                        if (count_q == CNT_W'(DEPTH - 1)) begin
                            state_q     <= StRun;
                            out_valid_q <= 1'b1;
                            out_value_q <= out_value_d;
                        end
                    end
                    StRun: begin
                        out_valid_q <= 1'b1;
                        out_value_q <= out_value_d;
                    end
                    default: begin
                        state_q <= StFill;
                    end
                endcase
            end
        end
    end

    assign OUT_VALUE = out_value_q;
    assign OUT_VALID = out_valid_q;

endmodule
